// File: rtl/floo_eos_pkg.sv
// End-of-simulation monitor shared types.
// State encoding and default timing constants.
package floo_eos_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE,
    TIMEOUT
  } eos_state_e;

  localparam int unsigned DefDrainCycles   = 10;
  localparam int unsigned DefTimeoutCycles = 1000000;

endpackage

// File: rtl/popcount.sv
// Population count of a bit vector.
// Purely combinational adder chain.
module popcount #(
  parameter int unsigned INPUT_WIDTH = 32,
  localparam int unsigned PopcountWidth = $clog2(INPUT_WIDTH + 1)
) (
  input  logic [INPUT_WIDTH-1:0]   data_i,
  output logic [PopcountWidth-1:0] popcount_o
);

  logic [PopcountWidth-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      cnt = cnt + PopcountWidth'(data_i[i]);
    end
  end

  assign popcount_o = cnt;

endmodule

// File: rtl/floo_eos_monitor.sv
// Collects per-tile end_of_sim flags, drains, then flags done.
// A RUN-cycle budget bounds the wait with a timeout state.
module floo_eos_monitor
  import floo_eos_pkg::*;
#(
  parameter int unsigned NumClusters   = 32,
  parameter int unsigned DrainCycles   = DefDrainCycles,
  parameter int unsigned TimeoutCycles = DefTimeoutCycles,
  parameter int unsigned CntWidth      = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               en_i,
  input  logic                               clear_i,
  input  logic [NumClusters-1:0]             eos_i,
  output logic [NumClusters-1:0]             done_mask_o,
  output logic [$clog2(NumClusters+1)-1:0]   done_cnt_o,
  output logic [CntWidth-1:0]                cycles_o,
  output logic                               done_o,
  output logic                               done_pulse_o,
  output logic                               timeout_o
);

  localparam logic [CntWidth-1:0] DrainInit =
    (DrainCycles == 0) ? '0 : CntWidth'(DrainCycles - 1);
  localparam logic [CntWidth-1:0] TimeoutLast =
    CntWidth'(TimeoutCycles - 1);

  eos_state_e state_q, state_d;
  logic [NumClusters-1:0] mask_q, mask_d;
  logic [CntWidth-1:0] cycles_q, cycles_d;
  logic [CntWidth-1:0] drain_q, drain_d;
  logic done_q, pulse_q, timeout_q;
  logic all_done;

  assign all_done = &(mask_q | eos_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      cycles_q  <= '0;
      drain_q   <= '0;
      done_q    <= 1'b0;
      pulse_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      cycles_q  <= cycles_d;
      drain_q   <= drain_d;
      done_q    <= (state_d == DONE);
      pulse_q   <= (state_d == DONE) && (state_q != DONE);
      timeout_q <= (state_d == TIMEOUT);
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cycles_d = cycles_q;
    drain_d  = drain_q;
    if (clear_i) begin
      state_d  = IDLE;
      mask_d   = '0;
      cycles_d = '0;
      drain_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en_i) state_d = RUN;
        end
        RUN: begin
          if (en_i) begin
            mask_d = mask_q | eos_i;
            if (!(&cycles_q)) begin
              cycles_d = cycles_q + CntWidth'(1);
            end
            // all-done beats a coincident timeout
            if (all_done) begin
              if (DrainCycles == 0) begin
                state_d = DONE;
              end else begin
                state_d = DRAIN;
                drain_d = DrainInit;
              end
            end else if (cycles_q == TimeoutLast) begin
              state_d = TIMEOUT;
            end
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_d = DONE;
          end else begin
            drain_d = drain_q - CntWidth'(1);
          end
        end
        DONE, TIMEOUT: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  popcount #(
    .INPUT_WIDTH(NumClusters)
  ) u_popcount (
    .data_i    (mask_q),
    .popcount_o(done_cnt_o)
  );

  assign done_mask_o  = mask_q;
  assign cycles_o     = cycles_q;
  assign done_o       = done_q;
  assign done_pulse_o = pulse_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_floo_eos_monitor.sv
// Bench for floo_eos_monitor: directed scenarios plus random
// traffic against a cycle-stamp reference model.
module tb_floo_eos_monitor;

  localparam int NC = 4;
  localparam int DC = 3;
  localparam int TC = 20;
  localparam int CW = 16;
  localparam int PW = $clog2(NC + 1);
  localparam longint CMAX = (64'd1 << CW) - 1;
  localparam int ALL = (1 << NC) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clear = 1'b0;
  logic [NC-1:0] eos = '0;
  logic [NC-1:0] mask;
  logic [PW-1:0] cnt;
  logic [CW-1:0] cycles;
  logic done, pulse, tmo;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  floo_eos_monitor #(
    .NumClusters  (NC),
    .DrainCycles  (DC),
    .TimeoutCycles(TC),
    .CntWidth     (CW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .clear_i     (clear),
    .eos_i       (eos),
    .done_mask_o (mask),
    .done_cnt_o  (cnt),
    .cycles_o    (cycles),
    .done_o      (done),
    .done_pulse_o(pulse),
    .timeout_o   (tmo)
  );

  // reference model: phase flags plus an absolute done deadline
  int m_mask = 0;
  longint m_cyc = 0;
  bit m_idle = 1'b1;
  bit m_run = 1'b0;
  bit m_drain = 1'b0;
  bit m_done = 1'b0;
  bit m_to = 1'b0;
  bit m_pulse = 1'b0;
  longint now = 0;
  longint deadline = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit was_done;
    was_done = m_done;
    now++;
    if (!rst_n || clear) begin
      m_mask = 0; m_cyc = 0;
      m_idle = 1; m_run = 0; m_drain = 0; m_done = 0; m_to = 0;
    end else if (m_idle) begin
      if (en) begin m_idle = 0; m_run = 1; end
    end else if (m_run) begin
      if (en) begin
        m_mask = m_mask | int'(eos);
        if (m_cyc < CMAX) m_cyc++;
        if (m_mask == ALL) begin
          m_run = 0;
          if (DC == 0) m_done = 1;
          else begin m_drain = 1; deadline = now + DC; end
        end else if (m_cyc == TC) begin
          m_run = 0; m_to = 1;
        end
      end
    end else if (m_drain) begin
      if (now >= deadline) begin m_drain = 0; m_done = 1; end
    end
    m_pulse = m_done && !was_done;
  endtask

  task automatic compare_all();
    check("mask", 32'(mask), 32'(m_mask));
    check("cnt", 32'(cnt), 32'($countones(m_mask)));
    check("cycles", 32'(cycles), 32'(m_cyc));
    check("done", 32'(done), 32'(m_done));
    check("pulse", 32'(pulse), 32'(m_pulse));
    check("timeout", 32'(tmo), 32'(m_to));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic restart();
    clear = 1'b1; en = 1'b0; eos = '0;
    tick();
    clear = 1'b0; en = 1'b1;
    tick();
  endtask

  initial begin
    int k;
    int pulses;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_done", 32'(done), 32'd0);
    check("rst_cycles", 32'(cycles), 32'd0);
    rst_n = 1'b1;
    tick();

    // staggered finish, then drain latency and a single pulse
    en = 1'b1;
    tick();
    eos = 4'b0001; tick();
    check("cnt_1", 32'(cnt), 32'd1);
    eos = 4'b0011; tick();
    eos = 4'b0111; tick();
    check("cnt_3", 32'(cnt), 32'd3);
    eos = 4'b1111; tick();
    check("cnt_4", 32'(cnt), 32'd4);
    k = 0;
    while (!done && k < 10) begin
      k++;
      tick();
    end
    check("drain_lat", 32'(k), 32'(DC));
    pulses = int'(pulse);
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses += int'(pulse);
    end
    check("pulse_cnt", 32'(pulses), 32'd1);

    // sticky mask, then frozen counters while disabled
    restart();
    eos = 4'b0010; tick();
    eos = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    check("sticky", 32'(mask), 32'h2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    en = 1'b1;
    tick();

    // timeout with one tile missing
    restart();
    eos = 4'b0111;
    k = 0;
    while (!tmo && k < 40) begin
      k++;
      tick();
    end
    check("to_seen", 32'(tmo), 32'd1);
    check("to_cycles", 32'(cycles), 32'(TC));
    check("to_nodone", 32'(done), 32'd0);

    // all-done on the last budget cycle wins over timeout
    restart();
    eos = '0;
    for (int i = 0; i < TC - 1; i++) tick();
    check("pre_race", 32'(cycles), 32'(TC - 1));
    eos = 4'b1111; tick();
    eos = '0;
    for (int i = 0; i < DC + 2; i++) begin
      tick();
      check("race_noto", 32'(tmo), 32'd0);
    end
    check("race_done", 32'(done), 32'd1);
    clear = 1'b1; en = 1'b0; tick();
    clear = 1'b0;
    check("clr_done", 32'(done), 32'd0);
    check("clr_mask", 32'(mask), 32'd0);

    // reset while draining
    en = 1'b1; tick();
    eos = 4'b1111; tick();
    eos = '0; tick();
    rst_n = 1'b0; tick();
    check("rst_drain_pulse", 32'(pulse), 32'd0);
    check("rst_drain_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < DC + 3; i++) tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom % 8) != 0;
      clear = ($urandom % 60) == 0;
      rst_n = ($urandom % 250) != 0;
      for (int b = 0; b < NC; b++) eos[b] = ($urandom % 6) == 0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/floo_eos_monitor.md
FLOO_EOS_MONITOR -- requirements
Module: floo_eos_monitor

Interface
REQ-001 SHALL have parameter NumClusters, default 32: number of compute tiles monitored.
REQ-002 SHALL have parameter DrainCycles, default 10: cycles waited after all tiles finish before done is asserted.
REQ-003 SHALL have parameter TimeoutCycles, default 1000000: RUN-state cycles allowed before timeout.
REQ-004 SHALL have parameter CntWidth, default 32: width of the cycle and drain counters.
REQ-005 SHALL have port clk_i, input, 1: the single clock; reset is synchronous and active-low.
REQ-006 SHALL have port rst_ni, input, 1: synchronous active-low reset.
REQ-007 SHALL have port en_i, input, 1: monitoring enable.
REQ-008 SHALL have port clear_i, input, 1: synchronous restart request.
REQ-009 SHALL have port eos_i, input, NumClusters: per-tile end_of_sim flag, already AND-reduced per tile.
REQ-010 SHALL have port done_mask_o, output, NumClusters: sticky per-tile finished mask.
REQ-011 SHALL have port done_cnt_o, output, $clog2(NumClusters+1): popcount of done_mask_o.
REQ-012 SHALL have port cycles_o, output, CntWidth: RUN cycles elapsed.
REQ-013 SHALL have port done_o, output, 1: level, high in DONE.
REQ-014 SHALL have port done_pulse_o, output, 1: single-cycle pulse on entry to DONE.
REQ-015 SHALL have port timeout_o, output, 1: level, high in TIMEOUT.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN, DRAIN, DONE and TIMEOUT.
REQ-017 SHALL go from IDLE to RUN on the cycle after en_i=1; mask and counters stay 0 while in IDLE.
REQ-018 In RUN with en_i=1, SHALL set done_mask_o[i] on the cycle after eos_i[i]=1; bits are sticky and later eos_i deassertion is ignored.
REQ-019 In RUN with en_i=1, SHALL increment cycles_o by 1 per cycle, saturating at all-ones.
REQ-020 In RUN with en_i=0, SHALL freeze mask, cycles_o and state.
REQ-021 In RUN, when (done_mask_o | eos_i) is all ones, SHALL go to DRAIN with the drain counter = DrainCycles-1, or straight to DONE if DrainCycles=0.
REQ-022 In RUN, when cycles_o = TimeoutCycles-1 and not all tiles are done, SHALL go to TIMEOUT; if both happen in the same cycle, all-done wins.
REQ-023 In DRAIN, SHALL decrement the drain counter every cycle regardless of en_i and eos_i, and go to DONE when it reaches 0; total latency from last eos_i to done_o is DrainCycles+1 cycles.
REQ-024 SHALL hold DONE and TIMEOUT until clear_i; done_mask_o and cycles_o hold their values there.
REQ-025 SHALL go to IDLE on the next cycle when clear_i=1 in any state, clearing mask and counters; clear_i takes priority over every other transition.
REQ-026 SHALL assert done_pulse_o for exactly one cycle, the first cycle done_o=1.
REQ-027 SHALL compute done_cnt_o combinationally from the registered done_mask_o.

Reset
REQ-028 SHALL return to IDLE on rst_ni=0 at a clock edge, from any state including DRAIN.
REQ-029 While in reset, SHALL drive done_mask_o=0, done_cnt_o=0, cycles_o=0, done_o=0, done_pulse_o=0 and timeout_o=0.
REQ-030 SHALL have no asynchronous reset paths.

Structure
REQ-031 SHALL define the state enum eos_state_e in shared package floo_eos_pkg, together with default DrainCycles/TimeoutCycles constants.
REQ-032 SHALL use the common_cells popcount as its only sub-module, for done_cnt_o.
REQ-033 SHALL use registered outputs only, except done_cnt_o.

Verification (NumClusters=4, DrainCycles=3, TimeoutCycles=20)
REQ-034 en_i=1, eos_i rising 0001,0011,0111,1111 one cycle apart -> done_cnt_o steps 1,2,3,4; done_o rises 4 cycles after eos_i=1111; done_pulse_o is high for 1 cycle.
REQ-035 eos_i=0010 pulsed for 1 cycle, then 0 -> done_mask_o stays 0010.
REQ-036 eos_i=0111 held -> timeout_o=1 when cycles_o=20; done_o stays 0.
REQ-037 eos_i=1111 on the same cycle that cycles_o=19 -> DRAIN then DONE; timeout_o never asserts.
REQ-038 en_i=0 for 5 cycles mid-RUN -> cycles_o frozen; clear_i in DONE -> IDLE, all outputs 0 next cycle.
REQ-039 rst_ni=0 during DRAIN -> all outputs 0 at the next edge; no done_pulse_o.
